// File: rtl/mem_arbiter_fsm.sv
// rtl/mem_arbiter_fsm.sv - two-requester round-robin arbiter for a synchronous-read memory
module mem_arbiter_fsm #(
  parameter int ADRS_WIDTH = 2,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADRS_WIDTH-1:0] adrs0,
  input  logic [ADRS_WIDTH-1:0] adrs1,
  input  logic [WORD_WIDTH-1:0] d_in0,
  input  logic [WORD_WIDTH-1:0] d_in1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADRS_WIDTH-1:0] mem_adrs,
  output logic [WORD_WIDTH-1:0] mem_d_in,
  input  logic [WORD_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  pick;
  logic                  winner;
  logic                  last_gnt;
  logic                  lat_we;
  logic [ADRS_WIDTH-1:0] adrs_r;
  logic [WORD_WIDTH-1:0] d_r;
  logic [WORD_WIDTH-1:0] rd_r;

  // Contention goes to whoever was not granted last; a lone request always wins.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    pick       = 1'b0;
    if (req0 && req1) pick = ~last_gnt;
    else              pick = req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      winner   <= 1'b0;
      last_gnt <= 1'b1;
      lat_we   <= 1'b0;
      adrs_r   <= '0;
      d_r      <= '0;
      rd_r     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        winner   <= pick;
        last_gnt <= pick;
        lat_we   <= pick ? we1 : we0;
        adrs_r   <= pick ? adrs1 : adrs0;
        d_r      <= pick ? d_in1 : d_in0;
      end
      // Memory was addressed from the acceptance edge, so mem_q is valid here.
      if (state == WAIT && !lat_we) rd_r <= mem_q;
    end
  end

  assign gnt0     = (state == ACCESS) && !winner;
  assign gnt1     = (state == ACCESS) &&  winner;
  assign done0    = (state == DONE)   && !winner;
  assign done1    = (state == DONE)   &&  winner;
  assign busy     = (state != IDLE);
  assign mem_we   = (state == ACCESS) && lat_we;
  assign mem_adrs = adrs_r;
  assign mem_d_in = d_r;
  assign rd_data  = rd_r;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// tb/tb_mem_arbiter_fsm.sv - directed self-checking bench for mem_arbiter_fsm
module tb_mem_arbiter_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [1:0] adrs0, adrs1;
  logic [7:0] d_in0, d_in1;
  logic       gnt0, gnt1, done0, done1, busy, mem_we;
  logic [7:0] rd_data;
  logic [1:0] mem_adrs;
  logic [7:0] mem_d_in;
  logic [7:0] mem_q;
  logic [7:0] mem [4];

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  mem_arbiter_fsm #(.ADRS_WIDTH(2), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adrs0(adrs0), .adrs1(adrs1), .d_in0(d_in0), .d_in1(d_in1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rd_data(rd_data), .busy(busy),
    .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_d_in(mem_d_in), .mem_q(mem_q)
  );

  // Synchronous-read memory with read-before-write.
  always @(posedge clk) begin
    if (mem_we) mem[mem_adrs] <= mem_d_in;
    mem_q <= mem[mem_adrs];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adrs0 = 0; adrs1 = 0; d_in0 = 0; d_in1 = 0;
    tick(); tick();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_gnt",    32'({gnt0, gnt1}), 0);
    chk("rst_done",   32'({done0, done1}), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rd",     32'(rd_data), 0);
    chk("rst_adrs",   32'(mem_adrs), 0);
    chk("rst_din",    32'(mem_d_in), 0);

    // Contention right after reset: requester 0 first, then alternating, 4 cycles apart.
    rst = 1'b0;
    req0 = 1; we0 = 0; adrs0 = 2'd0;
    req1 = 1; we1 = 0; adrs1 = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      chk("cont_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      chk("cont_adrs", 32'(mem_adrs), 32'(i % 2));
      chk("cont_we",   32'(mem_we), 0);
      tick();
      chk("cont_wait_gnt", 32'({gnt0, gnt1}), 0);
      tick();
      chk("cont_done", 32'({done0, done1}), (i % 2 == 0) ? 32'h2 : 32'h1);
      chk("cont_rd",   32'(rd_data), 32'h10 + 32'(i % 2));
      tick();
      chk("cont_idle", 32'(busy), 0);
    end
    req0 = 0; req1 = 0;
    tick();
    chk("cont_stay_idle", 32'(busy), 0);

    // Write A5 to address 2, then read it back.
    req0 = 1; we0 = 1; adrs0 = 2'd2; d_in0 = 8'hA5;
    tick();
    chk("wr_gnt0",   32'(gnt0), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_adrs",   32'(mem_adrs), 2);
    chk("wr_din",    32'(mem_d_in), 32'hA5);
    req0 = 0;
    tick();
    chk("wr_we_once", 32'(mem_we), 0);
    chk("wr_adrs_hold", 32'(mem_adrs), 2);
    tick();
    chk("wr_done0", 32'(done0), 1);
    chk("wr_we_done", 32'(mem_we), 0);
    tick();
    req0 = 1; we0 = 0; adrs0 = 2'd2;
    tick();
    chk("rd_gnt0", 32'(gnt0), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    req0 = 0;
    tick(); tick();
    chk("rd_done0", 32'(done0), 1);
    chk("rd_data",  32'(rd_data), 32'hA5);
    tick();

    // Single read by requester 1 from address 3: latency profile.
    req1 = 1; we1 = 0; adrs1 = 2'd3;
    tick();
    chk("lat_n1_gnt1", 32'(gnt1), 1);
    chk("lat_n1_busy", 32'(busy), 1);
    req1 = 0;
    tick();
    chk("lat_n2_busy", 32'(busy), 1);
    chk("lat_n2_done", 32'({done0, done1}), 0);
    tick();
    chk("lat_n3_done1", 32'(done1), 1);
    chk("lat_n3_busy",  32'(busy), 1);
    chk("lat_n3_rd",    32'(rd_data), 32'h13);
    tick();
    chk("lat_n4_idle", 32'(busy), 0);

    // Inputs changed after acceptance must not reach the memory.
    req0 = 1; we0 = 1; adrs0 = 2'd1; d_in0 = 8'h3C;
    tick();
    d_in0 = 8'hFF; adrs0 = 2'd3; req0 = 0;
    #1;
    chk("chg_din",  32'(mem_d_in), 32'h3C);
    chk("chg_adrs", 32'(mem_adrs), 1);
    tick(); tick(); tick();
    chk("chg_mem1", 32'(mem[1]), 32'h3C);
    chk("chg_mem3", 32'(mem[3]), 32'h13);

    // Read returns 5A, then a write leaves rd_data alone.
    req1 = 1; we1 = 1; adrs1 = 2'd3; d_in1 = 8'h5A;
    tick(); req1 = 0; tick(); tick(); tick();
    req1 = 1; we1 = 0;
    tick(); req1 = 0; tick(); tick();
    chk("keep_rd", 32'(rd_data), 32'h5A);
    tick();
    req0 = 1; we0 = 1; adrs0 = 2'd0; d_in0 = 8'h77;
    tick();
    chk("keep_acc", 32'(rd_data), 32'h5A);
    req0 = 0;
    tick();
    chk("keep_wait", 32'(rd_data), 32'h5A);
    tick();
    chk("keep_done0", 32'(done0), 1);
    chk("keep_done_rd", 32'(rd_data), 32'h5A);
    tick();

    // Reset during WAIT of a read aborts the transaction.
    req0 = 1; we0 = 0; adrs0 = 2'd3;
    tick(); req0 = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd",   32'(rd_data), 0);
    chk("abort_done", 32'({done0, done1}), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'({done0, done1, mem_we, busy}), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_fsm.md
MEM_ARBITER_FSM -- requirements
Module: mem_arbiter_fsm

Interface
REQ-001 Parameter ADRS_WIDTH, default 2, memory address width.
REQ-002 Parameter WORD_WIDTH, default 8, memory data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-004 Requester ports: req0/req1 input 1 (level access request); we0/we1 input 1 (1=write, 0=read); adrs0/adrs1 input ADRS_WIDTH (address); d_in0/d_in1 input WORD_WIDTH (write data).
REQ-005 Response ports: gnt0/gnt1 output 1 (one-cycle accept pulse); done0/done1 output 1 (one-cycle completion pulse); rd_data output WORD_WIDTH (read result); busy output 1 (transaction in progress).
REQ-006 Memory-side ports: mem_we output 1 (write enable); mem_adrs output ADRS_WIDTH (address); mem_d_in output WORD_WIDTH (write data); mem_q input WORD_WIDTH (synchronous-read data, valid one cycle after mem_adrs is presented).

Function
REQ-007 FSM states SHALL be IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3.
REQ-008 IDLE: if req0|req1 at a clock edge, the block SHALL latch the winner's we/adrs/d_in, record the winner and go to ACCESS; otherwise stay in IDLE.
REQ-009 Arbitration: one request only, that requester wins; both requesting, the requester not granted last wins (round-robin); the last-grant register SHALL be updated on acceptance.
REQ-010 ACCESS (1 cycle): gnt of the winner SHALL be 1; mem_adrs/mem_d_in SHALL show the latched values; mem_we SHALL equal the latched we; next state WAIT unconditionally.
REQ-011 WAIT (1 cycle): mem_we SHALL be 0; on a read, rd_data SHALL load mem_q at the end of this cycle; on a write, rd_data SHALL hold its value; next state DONE.
REQ-012 DONE (1 cycle): done of the winner SHALL be 1; rd_data valid for reads; next state IDLE unconditionally.
REQ-013 Latency: request sampled at edge N -> gnt high in cycle N+1 -> done high in cycle N+3; back in IDLE in cycle N+4; a new request SHALL be accepted no earlier than the edge ending cycle N+4 (one transaction per 4 cycles max).
REQ-014 gnt0/gnt1 and done0/done1 SHALL be mutually exclusive and never high in the same cycle as each other.
REQ-015 busy SHALL be 1 in ACCESS, WAIT, DONE and 0 in IDLE.
REQ-016 Requests arriving in non-IDLE states SHALL be ignored (not queued); a requester holding req high through DONE SHALL be treated as a new request in the following IDLE.
REQ-017 Requester inputs SHALL be sampled only at acceptance; changes after acceptance SHALL NOT affect the in-flight transaction.
REQ-018 mem_adrs and mem_d_in SHALL hold their last driven values outside ACCESS; mem_we SHALL be 1 only in ACCESS of a write.
REQ-019 All outputs SHALL be driven from registers or decoded from the state register only (no combinational path from req*/mem_q to outputs).

Reset
REQ-020 On rst=1 at a clock edge: state=IDLE; gnt*, done*, mem_we, busy=0; rd_data, mem_adrs, mem_d_in=0; last-grant=requester 1 (so requester 0 wins the first contention).
REQ-021 rst asserted mid-transaction SHALL abort it: no done pulse, no further mem_we, transaction is lost; rst SHALL take priority over all requests.

Verification
REQ-022 Write then read: req0 we0=1 adrs0=2 d_in0=8'hA5, then req0 we0=0 adrs0=2 -> mem_we=1 for exactly one cycle with mem_adrs=2, mem_d_in=A5; second transaction done0 with rd_data=8'hA5.
REQ-023 Contention after reset: req0 and req1 both high, reads of adrs 0 and 1 -> gnt0 first, then gnt1 four cycles later; with both held high, grants alternate 0,1,0,1.
REQ-024 Latency check: single read by req1 at edge N -> gnt1 in cycle N+1, done1 in N+3, busy high N+1..N+3, IDLE at N+4.
REQ-025 Input change after grant: req0 write adrs0=1 d_in0=3C, change d_in0 to FF during ACCESS -> memory receives 3C.
REQ-026 Reset mid-op: assert rst during WAIT of a read -> next cycle IDLE, done0/done1 never pulse, rd_data=0, busy=0.
REQ-027 Write preserves rd_data: read returns 8'h5A, then a write -> rd_data remains 8'h5A through the write's DONE.
